// File: rtl/bp_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the fetch (I) and
// load/store (D) miss paths, with a single outstanding transaction.
module bp_mem_arbiter #(
  parameter int paddr_width_p = 22,
  parameter int data_width_p  = 64
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     i_req_v_i,
  input  logic [paddr_width_p-1:0] i_req_addr_i,
  output logic                     i_req_ready_o,
  input  logic                     d_req_v_i,
  input  logic                     d_req_we_i,
  input  logic [paddr_width_p-1:0] d_req_addr_i,
  input  logic [data_width_p-1:0]  d_req_data_i,
  output logic                     d_req_ready_o,
  output logic                     mem_req_v_o,
  output logic                     mem_req_we_o,
  output logic [paddr_width_p-1:0] mem_req_addr_o,
  output logic [data_width_p-1:0]  mem_req_data_o,
  input  logic                     mem_req_ready_i,
  input  logic                     mem_resp_v_i,
  input  logic [data_width_p-1:0]  mem_resp_data_i,
  output logic                     i_resp_v_o,
  output logic [data_width_p-1:0]  i_resp_data_o,
  output logic                     d_resp_v_o,
  output logic [data_width_p-1:0]  d_resp_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} grant_e;

  state_e                   r_state;
  grant_e                   r_grant;
  grant_e                   r_last_grant;
  logic                     r_we;
  logic [paddr_width_p-1:0] r_addr;
  logic [data_width_p-1:0]  r_data;

  logic w_idle;
  logic w_win_i;
  logic w_win_d;
  logic w_resp;

  // I wins a tie only when D was served last, so a held requester cannot starve the other.
  assign w_idle  = (r_state == S_IDLE) & ~reset_i;
  assign w_win_i = i_req_v_i & (~d_req_v_i | (r_last_grant == GNT_D));
  assign w_win_d = d_req_v_i & ~w_win_i;

  assign i_req_ready_o = w_idle & w_win_i;
  assign d_req_ready_o = w_idle & w_win_d;

  assign mem_req_v_o    = (r_state == S_ISSUE);
  assign mem_req_we_o   = r_we;
  assign mem_req_addr_o = r_addr;
  assign mem_req_data_o = r_data;

  // Responses arriving outside WAIT, or while reset abandons the transaction, are dropped.
  assign w_resp        = (r_state == S_WAIT) & mem_resp_v_i & ~reset_i;
  assign i_resp_v_o    = w_resp & (r_grant == GNT_I);
  assign d_resp_v_o    = w_resp & (r_grant == GNT_D);
  assign i_resp_data_o = mem_resp_data_i;
  assign d_resp_data_o = mem_resp_data_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= S_IDLE;
      r_grant      <= GNT_I;
      r_last_grant <= GNT_D;
      // NOTE: the request buffer is reset because it drives the memory
      // address/data outputs directly and they must read zero out of reset.
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_req_ready_o) begin
            r_we         <= 1'b0;
            r_addr       <= i_req_addr_i;
            r_data       <= '0;
            r_grant      <= GNT_I;
            r_last_grant <= GNT_I;
            r_state      <= S_ISSUE;
          end else if (d_req_ready_o) begin
            r_we         <= d_req_we_i;
            r_addr       <= d_req_addr_i;
            r_data       <= d_req_we_i ? d_req_data_i : '0;
            r_grant      <= GNT_D;
            r_last_grant <= GNT_D;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_req_ready_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_v_i) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_mem_arbiter.sv
// Directed self-checking bench for bp_mem_arbiter: inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
module tb_bp_mem_arbiter;

  localparam int PW = 22;
  localparam int DW = 64;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          i_req_v_i;
  logic [PW-1:0] i_req_addr_i;
  logic          i_req_ready_o;
  logic          d_req_v_i;
  logic          d_req_we_i;
  logic [PW-1:0] d_req_addr_i;
  logic [DW-1:0] d_req_data_i;
  logic          d_req_ready_o;
  logic          mem_req_v_o;
  logic          mem_req_we_o;
  logic [PW-1:0] mem_req_addr_o;
  logic [DW-1:0] mem_req_data_o;
  logic          mem_req_ready_i;
  logic          mem_resp_v_i;
  logic [DW-1:0] mem_resp_data_i;
  logic          i_resp_v_o;
  logic [DW-1:0] i_resp_data_o;
  logic          d_resp_v_o;
  logic [DW-1:0] d_resp_data_o;

  int errors = 0;
  int checks = 0;

  bp_mem_arbiter #(.paddr_width_p(PW), .data_width_p(DW)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .i_req_v_i       (i_req_v_i),
    .i_req_addr_i    (i_req_addr_i),
    .i_req_ready_o   (i_req_ready_o),
    .d_req_v_i       (d_req_v_i),
    .d_req_we_i      (d_req_we_i),
    .d_req_addr_i    (d_req_addr_i),
    .d_req_data_i    (d_req_data_i),
    .d_req_ready_o   (d_req_ready_o),
    .mem_req_v_o     (mem_req_v_o),
    .mem_req_we_o    (mem_req_we_o),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_data_o  (mem_req_data_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_data_i (mem_resp_data_i),
    .i_resp_v_o      (i_resp_v_o),
    .i_resp_data_o   (i_resp_data_o),
    .d_resp_v_o      (d_resp_v_o),
    .d_resp_data_o   (d_resp_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  // One full transaction from the IDLE acceptance cycle to the response
  // cycle; the requester inputs must already be driven by the caller.
  task automatic txn(input string tag, input bit exp_i, input logic [PW-1:0] exp_addr,
                     input bit exp_we, input logic [DW-1:0] exp_data,
                     input logic [DW-1:0] rdata, input int stall);
    @(negedge clk_i);
    check({tag, ":i_ready"}, i_req_ready_o, exp_i);
    check({tag, ":d_ready"}, d_req_ready_o, !exp_i);
    check({tag, ":idle_mem_v"}, mem_req_v_o, 0);
    next_cyc();
    for (int k = 0; k <= stall; k++) begin
      mem_req_ready_i = (k == stall);
      @(negedge clk_i);
      check({tag, ":mem_v"}, mem_req_v_o, 1);
      check({tag, ":mem_addr"}, mem_req_addr_o, exp_addr);
      check({tag, ":mem_we"}, mem_req_we_o, exp_we);
      check({tag, ":mem_data"}, mem_req_data_o, exp_data);
      check({tag, ":busy_rdy"}, {i_req_ready_o, d_req_ready_o}, 0);
      next_cyc();
    end
    mem_req_ready_i = 1'b0;
    mem_resp_v_i    = 1'b1;
    mem_resp_data_i = rdata;
    @(negedge clk_i);
    check({tag, ":i_resp_v"}, i_resp_v_o, exp_i);
    check({tag, ":d_resp_v"}, d_resp_v_o, !exp_i);
    check({tag, ":resp_data"}, exp_i ? i_resp_data_o : d_resp_data_o, rdata);
    check({tag, ":wait_mem_v"}, mem_req_v_o, 0);
    next_cyc();
    mem_resp_v_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i = 1'b1;
    i_req_v_i = 1'b0; i_req_addr_i = '0;
    d_req_v_i = 1'b0; d_req_we_i = 1'b0; d_req_addr_i = '0; d_req_data_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_v_i = 1'b0; mem_resp_data_i = '0;
    next_cyc();
    next_cyc();
    reset_i = 1'b0;

    // Reset state
    @(negedge clk_i);
    check("rst:mem_v", mem_req_v_o, 0);
    check("rst:mem_addr", mem_req_addr_o, 0);
    check("rst:mem_data", mem_req_data_o, 0);
    check("rst:mem_we", mem_req_we_o, 0);
    check("rst:resp_v", {i_resp_v_o, d_resp_v_o}, 0);
    check("rst:ready", {i_req_ready_o, d_req_ready_o}, 0);
    next_cyc();

    // Single fetch
    i_req_v_i = 1'b1; i_req_addr_i = 22'h00040;
    txn("fetch", 1'b1, 22'h00040, 1'b0, 64'h0, 64'hDEADBEEF_00000001, 0);
    i_req_v_i = 1'b0;
    @(negedge clk_i);
    check("fetch:pulse_end", i_resp_v_o, 0);
    next_cyc();

    // Tie after reset: I first, then strict alternation
    reset_i = 1'b1;
    next_cyc();
    reset_i = 1'b0;
    i_req_v_i = 1'b1; i_req_addr_i = 22'h00100;
    d_req_v_i = 1'b1; d_req_we_i = 1'b0; d_req_addr_i = 22'h3FFF8;
    d_req_data_i = 64'hAAAA_5555_AAAA_5555;
    txn("tie1_I", 1'b1, 22'h00100, 1'b0, 64'h0, 64'h0000_0000_0000_1111, 0);
    txn("tie2_D", 1'b0, 22'h3FFF8, 1'b0, 64'h0, 64'h0000_0000_0000_2222, 0);
    txn("tie3_I", 1'b1, 22'h00100, 1'b0, 64'h0, 64'h0000_0000_0000_3333, 0);
    txn("tie4_D", 1'b0, 22'h3FFF8, 1'b0, 64'h0, 64'h0000_0000_0000_4444, 0);
    i_req_v_i = 1'b0; d_req_v_i = 1'b0;

    // Store held under five cycles of backpressure
    d_req_v_i = 1'b1; d_req_we_i = 1'b1; d_req_addr_i = 22'h01008;
    d_req_data_i = 64'h1122334455667788;
    txn("store", 1'b0, 22'h01008, 1'b1, 64'h1122334455667788, 64'h0000_0000_0000_0ACC, 5);
    d_req_v_i = 1'b0; d_req_we_i = 1'b0;

    // Stray response and ready while IDLE
    mem_resp_v_i = 1'b1; mem_req_ready_i = 1'b1; mem_resp_data_i = 64'hBAD;
    @(negedge clk_i);
    check("stray_idle:resp_v", {i_resp_v_o, d_resp_v_o}, 0);
    next_cyc();
    mem_resp_v_i = 1'b0; mem_req_ready_i = 1'b0;
    @(negedge clk_i);
    check("stray_idle:mem_v", mem_req_v_o, 0);
    next_cyc();

    // Stray response while ISSUE
    i_req_v_i = 1'b1; i_req_addr_i = 22'h00500;
    @(negedge clk_i);
    check("stray_iss:i_ready", i_req_ready_o, 1);
    next_cyc();
    i_req_v_i = 1'b0; mem_resp_v_i = 1'b1;
    @(negedge clk_i);
    check("stray_iss:resp_v", {i_resp_v_o, d_resp_v_o}, 0);
    check("stray_iss:mem_v", mem_req_v_o, 1);
    next_cyc();
    mem_resp_v_i = 1'b0;
    @(negedge clk_i);
    check("stray_iss:still_issue", mem_req_v_o, 1);
    check("stray_iss:addr", mem_req_addr_o, 22'h00500);
    mem_req_ready_i = 1'b1;
    next_cyc();
    mem_req_ready_i = 1'b0; mem_resp_v_i = 1'b1; mem_resp_data_i = 64'h0000_0000_0000_5A5A;
    @(negedge clk_i);
    check("stray_iss:i_resp_v", i_resp_v_o, 1);
    check("stray_iss:i_resp_data", i_resp_data_o, 64'h5A5A);
    next_cyc();
    mem_resp_v_i = 1'b0;

    // Reset while waiting for a response
    i_req_v_i = 1'b1; i_req_addr_i = 22'h00200;
    @(negedge clk_i);
    check("rstwait:i_ready", i_req_ready_o, 1);
    next_cyc();
    i_req_v_i = 1'b0; mem_req_ready_i = 1'b1;
    @(negedge clk_i);
    check("rstwait:mem_v", mem_req_v_o, 1);
    next_cyc();
    mem_req_ready_i = 1'b0; reset_i = 1'b1;
    @(negedge clk_i);
    check("rstwait:no_resp", {i_resp_v_o, d_resp_v_o}, 0);
    next_cyc();
    reset_i = 1'b0; mem_resp_v_i = 1'b1; mem_resp_data_i = 64'hDEAD;
    @(negedge clk_i);
    check("rstwait:late_resp", {i_resp_v_o, d_resp_v_o}, 0);
    check("rstwait:mem_v", mem_req_v_o, 0);
    check("rstwait:mem_addr", mem_req_addr_o, 0);
    next_cyc();
    mem_resp_v_i = 1'b0;
    d_req_v_i = 1'b1; d_req_we_i = 1'b0; d_req_addr_i = 22'h00300; d_req_data_i = 64'h55;
    txn("rstwait_D", 1'b0, 22'h00300, 1'b0, 64'h0, 64'h0000_0000_CAFE_0001, 0);

    // D continuously valid with new requests; I asserted once wins next IDLE
    d_req_addr_i = 22'h00400;
    txn("starve_D1", 1'b0, 22'h00400, 1'b0, 64'h0, 64'h0000_0000_0000_0401, 0);
    d_req_addr_i = 22'h00408;
    i_req_v_i = 1'b1; i_req_addr_i = 22'h00600;
    txn("starve_I", 1'b1, 22'h00600, 1'b0, 64'h0, 64'h0000_0000_0000_0601, 0);
    i_req_v_i = 1'b0;
    txn("starve_D2", 1'b0, 22'h00408, 1'b0, 64'h0, 64'h0000_0000_0000_0409, 0);
    d_req_v_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
